// File: rtl/mul_div_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : mul_div_unit_if
// Description : Request/response bundle between the pipeline and mul_div_unit.
// Revision    : 1.0 - initial release
// ============================================================================
interface mul_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             md_start;
    logic [2:0]       md_op;
    logic [WIDTH-1:0] md_op_x;
    logic [WIDTH-1:0] md_op_y;
    logic             md_abort;
    logic             md_busy;
    logic             md_done;
    logic             md_div_zero;
    logic [WIDTH-1:0] md_hi;
    logic [WIDTH-1:0] md_lo;

    modport master (
        output md_start,
        output md_op,
        output md_op_x,
        output md_op_y,
        output md_abort,
        input  md_busy,
        input  md_done,
        input  md_div_zero,
        input  md_hi,
        input  md_lo
    );

    modport slave (
        input  md_start,
        input  md_op,
        input  md_op_x,
        input  md_op_y,
        input  md_abort,
        output md_busy,
        output md_done,
        output md_div_zero,
        output md_hi,
        output md_lo
    );
endinterface
`default_nettype wire

// File: rtl/mul_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : mul_div_unit
// Description : Iterative 1-bit/cycle multiply/divide unit with HI/LO registers.
// Revision    : 1.0 - initial release
// ============================================================================
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  wire logic     clk,
    input  wire logic     rst,
    mul_div_unit_if.slave md
);

    localparam int CW = $clog2(WIDTH) + 1;

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    localparam logic [2:0] c_OP_MULT  = 3'b000;
    localparam logic [2:0] c_OP_MULTU = 3'b001;
    localparam logic [2:0] c_OP_DIV   = 3'b010;
    localparam logic [2:0] c_OP_DIVU  = 3'b011;
    localparam logic [2:0] c_OP_MTHI  = 3'b100;
    localparam logic [2:0] c_OP_MTLO  = 3'b101;

    localparam logic [CW-1:0] c_CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] c_CNT_ONE  = CW'(1);

    logic [1:0]       r_state;
    logic [CW-1:0]    r_cnt;
    logic             r_is_div;
    logic             r_neg_q;
    logic             r_neg_r;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_done;
    logic             r_div_zero;

    logic             w_accept;
    logic             w_signed;
    logic             w_x_neg;
    logic             w_y_neg;
    logic [WIDTH-1:0] w_x_mag;
    logic [WIDTH-1:0] w_y_mag;
    logic             w_y_zero;

    logic [WIDTH:0]     w_mul_sum;
    logic [WIDTH:0]     w_div_shift;
    logic               w_div_ok;
    logic [WIDTH-1:0]   w_div_diff;
    logic [WIDTH-1:0]   w_next_acc;
    logic [WIDTH-1:0]   w_next_q;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_quo_fix;
    logic [WIDTH-1:0]   w_rem_fix;

    // Abort always wins over a same-cycle start; RUN ignores starts entirely.
    assign w_accept = md.md_start && !md.md_abort && (r_state != c_RUN);

    // Even opcodes (MULT, DIV) are the signed variants.
    assign w_signed = ~md.md_op[0];
    assign w_x_neg  = w_signed & md.md_op_x[WIDTH-1];
    assign w_y_neg  = w_signed & md.md_op_y[WIDTH-1];
    assign w_x_mag  = w_x_neg ? -md.md_op_x : md.md_op_x;
    assign w_y_mag  = w_y_neg ? -md.md_op_y : md.md_op_y;
    assign w_y_zero = (md.md_op_y == '0);

    assign w_mul_sum   = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_b} : '0);
    assign w_div_shift = {r_acc, r_q[WIDTH-1]};
    assign w_div_ok    = (w_div_shift >= {1'b0, r_b});
    // Only used when w_div_ok, where the true difference always fits WIDTH bits.
    assign w_div_diff  = w_div_shift[WIDTH-1:0] - r_b;

    always_comb begin
        w_next_acc = r_acc;
        w_next_q   = r_q;
        if (r_is_div) begin
            w_next_acc = w_div_ok ? w_div_diff : w_div_shift[WIDTH-1:0];
            w_next_q   = {r_q[WIDTH-2:0], w_div_ok};
        end else begin
            w_next_acc = w_mul_sum[WIDTH:1];
            w_next_q   = {w_mul_sum[0], r_q[WIDTH-1:1]};
        end
    end

    assign w_prod     = {w_next_acc, w_next_q};
    assign w_prod_fix = r_neg_q ? -w_prod : w_prod;
    assign w_quo_fix  = r_neg_q ? -w_next_q : w_next_q;
    assign w_rem_fix  = r_neg_r ? -w_next_acc : w_next_acc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_IDLE;
            r_cnt      <= '0;
            r_is_div   <= 1'b0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_b        <= '0;
            r_acc      <= '0;
            r_q        <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
        end else begin
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
            case (r_state)
                c_RUN: begin
                    if (md.md_abort) begin
                        r_state <= c_IDLE;
                    end else begin
                        r_acc <= w_next_acc;
                        r_q   <= w_next_q;
                        r_cnt <= r_cnt + c_CNT_ONE;
                        if (r_cnt == c_CNT_LAST) begin
                            r_state <= c_DONE;
                            r_done  <= 1'b1;
                            if (r_is_div) begin
                                r_hi <= w_rem_fix;
                                r_lo <= w_quo_fix;
                            end else begin
                                r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
                                r_lo <= w_prod_fix[WIDTH-1:0];
                            end
                        end
                    end
                end
                default: begin
                    if (w_accept) begin
                        r_cnt <= '0;
                        case (md.md_op)
                            c_OP_MULT, c_OP_MULTU: begin
                                r_state  <= c_RUN;
                                r_is_div <= 1'b0;
                                r_neg_q  <= w_x_neg ^ w_y_neg;
                                r_neg_r  <= 1'b0;
                                r_b      <= w_y_mag;
                                r_acc    <= '0;
                                r_q      <= w_x_mag;
                            end
                            c_OP_DIV, c_OP_DIVU: begin
                                if (w_y_zero) begin
                                    r_state    <= c_DONE;
                                    r_done     <= 1'b1;
                                    r_div_zero <= 1'b1;
                                end else begin
                                    r_state  <= c_RUN;
                                    r_is_div <= 1'b1;
                                    r_neg_q  <= w_x_neg ^ w_y_neg;
                                    r_neg_r  <= w_x_neg;
                                    r_b      <= w_y_mag;
                                    r_acc    <= '0;
                                    r_q      <= w_x_mag;
                                end
                            end
                            c_OP_MTHI: begin
                                r_state <= c_DONE;
                                r_done  <= 1'b1;
                                r_hi    <= md.md_op_x;
                            end
                            c_OP_MTLO: begin
                                r_state <= c_DONE;
                                r_done  <= 1'b1;
                                r_lo    <= md.md_op_x;
                            end
                            default: begin
                                r_state <= r_state;
                            end
                        endcase
                    end else begin
                        r_state <= c_IDLE;
                    end
                end
            endcase
        end
    end

    assign md.md_busy     = (r_state == c_RUN);
    assign md.md_done     = r_done;
    assign md.md_div_zero = r_div_zero;
    assign md.md_hi       = r_hi;
    assign md.md_lo       = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_mul_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mul_div_unit
// Description : Directed plus random checks of mul_div_unit against a plain-arithmetic model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mul_div_unit;

    localparam int WIDTH = 32;

    logic clk;
    logic rst;
    int   n_assert;
    int   n_fail;

    logic [31:0] exp_hi;
    logic [31:0] exp_lo;

    mul_div_unit_if #(.WIDTH(WIDTH)) bus ();

    mul_div_unit #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .md  (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Model result of one operation from plain integer arithmetic.
    task automatic model(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                         output logic dz);
        longint      sa, sb, sq, sr;
        logic [63:0] p, ua, ub, uq, ur;
        dz = 1'b0;
        sa = longint'($signed(x));
        sb = longint'($signed(y));
        ua = {32'h0, x};
        ub = {32'h0, y};
        case (op)
            3'd0: begin p = sa * sb; exp_hi = p[63:32]; exp_lo = p[31:0]; end
            3'd1: begin p = ua * ub; exp_hi = p[63:32]; exp_lo = p[31:0]; end
            3'd2: begin
                if (y == 32'h0) dz = 1'b1;
                else begin
                    sq = sa / sb; sr = sa % sb;
                    exp_lo = sq[31:0]; exp_hi = sr[31:0];
                end
            end
            3'd3: begin
                if (y == 32'h0) dz = 1'b1;
                else begin
                    uq = ua / ub; ur = ua % ub;
                    exp_lo = uq[31:0]; exp_hi = ur[31:0];
                end
            end
            3'd4: exp_hi = x;
            3'd5: exp_lo = x;
            default: ;
        endcase
    endtask

    // Issues an op in the current cycle and follows it to its done cycle.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] x,
                          input logic [31:0] y);
        logic dz;
        int   n;
        model(op, x, y, dz);
        bus.md_start = 1'b1;
        bus.md_op    = op;
        bus.md_op_x  = x;
        bus.md_op_y  = y;
        tick();
        bus.md_start = 1'b0;
        if (op <= 3'd3 && !dz) begin
            n = 0;
            while (bus.md_busy && n < 40) begin
                n++;
                tick();
            end
            check({tag, " busy_cycles"}, 64'(n), 64'd32);
        end else begin
            check({tag, " busy"}, 64'(bus.md_busy), 64'd0);
        end
        check({tag, " done"}, 64'(bus.md_done), 64'd1);
        check({tag, " div_zero"}, 64'(bus.md_div_zero), 64'(dz));
        check({tag, " hi"}, 64'(bus.md_hi), 64'(exp_hi));
        check({tag, " lo"}, 64'(bus.md_lo), 64'(exp_lo));
    endtask

    initial begin
        logic [2:0]  op;
        logic [31:0] x, y;
        logic        seen;

        n_assert = 0;
        n_fail   = 0;
        exp_hi   = 32'h0;
        exp_lo   = 32'h0;
        rst          = 1'b1;
        bus.md_start = 1'b0;
        bus.md_op    = 3'd0;
        bus.md_op_x  = 32'h0;
        bus.md_op_y  = 32'h0;
        bus.md_abort = 1'b0;
        repeat (3) tick();
        check("rst busy", 64'(bus.md_busy), 64'd0);
        check("rst done", 64'(bus.md_done), 64'd0);
        check("rst dz",   64'(bus.md_div_zero), 64'd0);
        check("rst hi",   64'(bus.md_hi), 64'd0);
        check("rst lo",   64'(bus.md_lo), 64'd0);
        rst = 1'b0;
        tick();

        run_op("mult_neg", 3'd0, 32'hFFFFFFFD, 32'h00000007);
        check("mult_neg hi_const", 64'(bus.md_hi), 64'hFFFFFFFF);
        check("mult_neg lo_const", 64'(bus.md_lo), 64'hFFFFFFEB);
        tick();
        check("done_pulse_width", 64'(bus.md_done), 64'd0);

        run_op("multu_max", 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
        check("multu_max hi_const", 64'(bus.md_hi), 64'hFFFFFFFE);
        run_op("div_b2b", 3'd2, 32'hFFFFFFF9, 32'h00000002);
        check("div_b2b lo_const", 64'(bus.md_lo), 64'hFFFFFFFD);
        check("div_b2b hi_const", 64'(bus.md_hi), 64'hFFFFFFFF);
        tick();

        run_op("div_ovf", 3'd2, 32'h80000000, 32'hFFFFFFFF);
        check("div_ovf lo_const", 64'(bus.md_lo), 64'h80000000);
        tick();

        run_op("mthi", 3'd4, 32'h12345678, 32'h0);
        tick();
        run_op("divu_zero", 3'd3, 32'h00000007, 32'h0);
        check("divu_zero hi_const", 64'(bus.md_hi), 64'h12345678);
        tick();

        // Ignored start during RUN, then abort.
        run_op("pre_abort_mtlo", 3'd5, 32'hCAFEF00D, 32'h0);
        bus.md_start = 1'b1; bus.md_op = 3'd1;
        bus.md_op_x = 32'h0000FFFF; bus.md_op_y = 32'h0000FFFF;
        tick();
        bus.md_start = 1'b0;
        repeat (4) tick();
        bus.md_start = 1'b1; bus.md_op = 3'd4; bus.md_op_x = 32'hDEADBEEF;
        tick();
        bus.md_start = 1'b0;
        check("ignored_start busy", 64'(bus.md_busy), 64'd1);
        repeat (4) tick();
        bus.md_abort = 1'b1;
        tick();
        bus.md_abort = 1'b0;
        check("abort busy", 64'(bus.md_busy), 64'd0);
        check("abort done", 64'(bus.md_done), 64'd0);
        seen = 1'b0;
        repeat (40) begin
            tick();
            if (bus.md_done) seen = 1'b1;
        end
        check("abort no_done", 64'(seen), 64'd0);
        check("abort hi", 64'(bus.md_hi), 64'(exp_hi));
        check("abort lo", 64'(bus.md_lo), 64'(exp_lo));

        // Abort in IDLE drops a start; no-op codes do nothing.
        bus.md_start = 1'b1; bus.md_op = 3'd5; bus.md_op_x = 32'h11111111; bus.md_abort = 1'b1;
        tick();
        bus.md_start = 1'b0; bus.md_abort = 1'b0;
        check("idle_abort done", 64'(bus.md_done), 64'd0);
        check("idle_abort lo", 64'(bus.md_lo), 64'(exp_lo));
        bus.md_start = 1'b1; bus.md_op = 3'd6; bus.md_op_x = 32'h22222222;
        tick();
        bus.md_start = 1'b0;
        check("noop done", 64'(bus.md_done), 64'd0);
        check("noop busy", 64'(bus.md_busy), 64'd0);
        check("noop hi", 64'(bus.md_hi), 64'(exp_hi));

        // Reset mid-run, then a start on the first cycle out of reset.
        bus.md_start = 1'b1; bus.md_op = 3'd0;
        bus.md_op_x = 32'h12345; bus.md_op_y = 32'h6789;
        tick();
        bus.md_start = 1'b0;
        repeat (19) tick();
        rst = 1'b1;
        tick();
        exp_hi = 32'h0;
        exp_lo = 32'h0;
        check("midrst busy", 64'(bus.md_busy), 64'd0);
        check("midrst done", 64'(bus.md_done), 64'd0);
        check("midrst dz",   64'(bus.md_div_zero), 64'd0);
        check("midrst hi",   64'(bus.md_hi), 64'd0);
        check("midrst lo",   64'(bus.md_lo), 64'd0);
        rst = 1'b0;
        run_op("post_rst_mult", 3'd0, 32'h80000000, 32'h80000000);

        for (int i = 0; i < 24; i++) begin
            op = 3'($urandom_range(0, 5));
            x  = $urandom;
            y  = $urandom;
            if ($urandom_range(0, 7) == 0) y = 32'h0;
            if ($urandom_range(0, 7) == 0) x = 32'h80000000;
            if ($urandom_range(0, 7) == 0) y = 32'hFFFFFFFF;
            if ($urandom_range(0, 3) == 0) y = y >> $urandom_range(1, 30);
            run_op("random", op, x, y);
            if ($urandom_range(0, 1) == 0) tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving operand/HI/LO width; legal range 4..64.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port md_start  input  1  request; accepted only when the block is in IDLE or DONE.
REQ-005 SHALL have port md_op  input  3  operation: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 are no-ops.
REQ-006 SHALL have port md_op_x  input  WIDTH  multiplicand/dividend, or MTHI/MTLO source.
REQ-007 SHALL have port md_op_y  input  WIDTH  multiplier/divisor.
REQ-008 SHALL have port md_abort  input  1  pipeline flush; cancels an in-flight operation.
REQ-009 SHALL have port md_busy  output  1  iteration in progress.
REQ-010 SHALL have port md_done  output  1  one-cycle completion pulse.
REQ-011 SHALL have port md_div_zero  output  1  qualifies md_done: DIV/DIVU with md_op_y == 0.
REQ-012 SHALL have ports md_hi and md_lo  output  WIDTH  architectural HI/LO registers, always readable.

Function
REQ-013 SHALL implement states IDLE, RUN, DONE; IDLE->RUN or DONE->RUN on accepted MULT/MULTU/DIV/DIVU with nonzero divisor; RUN->DONE after WIDTH iterations; DONE->IDLE when no start is accepted.
REQ-014 SHALL, on an edge accepting a start, latch operand magnitudes, result signs, the op, and clear the iteration counter (width clog2(WIDTH)+1).
REQ-015 SHALL perform one shift-add (multiply) or one restoring shift-subtract (divide) step per RUN cycle, processing 1 bit per cycle.
REQ-016 SHALL assert md_busy in every cycle after the accepting edge through the edge performing iteration WIDTH, i.e. exactly WIDTH cycles.
REQ-017 SHALL write HI/LO on the edge performing the final iteration, and assert md_done (md_busy=0) for exactly the following cycle.
REQ-018 SHALL produce for MULT/MULTU the 2*WIDTH-bit product {HI,LO}, signed or unsigned respectively.
REQ-019 SHALL produce for DIV/DIVU the quotient in LO and the remainder in HI, with quotient truncated toward zero and remainder sign equal to the dividend sign.
REQ-020 SHALL, for signed DIV of most-negative by -1, give LO = most-negative and HI = 0, with no flag.
REQ-021 SHALL, for DIV/DIVU with md_op_y == 0, skip RUN, leave HI/LO unchanged, and assert md_done and md_div_zero together for one cycle after the accepting edge.
REQ-022 SHALL, for MTHI/MTLO, write md_op_x to HI/LO on the accepting edge and assert md_done for the next cycle, without asserting md_busy.
REQ-023 SHALL ignore md_start while in RUN, with no effect on state, operands or HI/LO.
REQ-024 SHALL accept md_start in the DONE cycle, so back-to-back operations incur no idle cycle.
REQ-025 SHALL, on md_abort in RUN, go to IDLE on that edge with HI/LO unchanged, and assert no md_done.
REQ-026 SHALL give md_abort priority over a concurrent md_start, which is dropped.
REQ-027 SHALL treat md_abort in IDLE/DONE as dropping any same-cycle md_start; it has no other effect.
REQ-028 SHALL accept no-op md_op values 110/111 as a start without changing state; no md_done is produced.

Reset
REQ-029 SHALL, while rst=1 at an edge, force IDLE, md_hi=0, md_lo=0, md_busy=0, md_done=0, md_div_zero=0, and counter=0.
REQ-030 SHALL give rst priority over md_start and md_abort; rst in RUN discards the operation and produces no md_done.

Verification (WIDTH=32)
REQ-031 SHALL cover: MULT x=FFFFFFFD, y=00000007 -> busy 32 cycles, then done pulse; HI=FFFFFFFF, LO=FFFFFFEB.
REQ-032 SHALL cover: MULTU x=y=FFFFFFFF -> HI=FFFFFFFE, LO=00000001; immediately followed by a start in the DONE cycle, DIV x=FFFFFFF9, y=00000002 -> LO=FFFFFFFD, HI=FFFFFFFF.
REQ-033 SHALL cover: DIV x=80000000, y=FFFFFFFF -> LO=80000000, HI=00000000, div_zero=0.
REQ-034 SHALL cover: preload MTHI 12345678, then DIVU x=7, y=0 -> next cycle done=1, div_zero=1, busy never high; HI=12345678.
REQ-035 SHALL cover: MULTU started, start pulsed at busy cycle 5 (ignored), abort at busy cycle 10 -> IDLE, no done, HI/LO unchanged.
REQ-036 SHALL cover: rst asserted at busy cycle 20 -> next cycle all outputs 0, HI=LO=0; a new MULT accepted on the first cycle after rst deasserts.
